// File: rtl/mul_sequencer_if.sv
// ============================================================================
// Module   : mul_sequencer_if
// Brief    : EX-stage handshake between the pipeline and the multiply sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mul_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              ex_valid;
    logic [3:0]        alu_control;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic              flush;
    logic              stall;
    logic              busy;
    logic [DATA_W-1:0] result;
    logic              result_valid;

    modport master (
        output ex_valid, alu_control, operand_a, operand_b, flush,
        input  stall, busy, result, result_valid
    );

    modport slave (
        input  ex_valid, alu_control, operand_a, operand_b, flush,
        output stall, busy, result, result_valid
    );
endinterface

`default_nettype wire

// File: rtl/mul_sequencer.sv
// ============================================================================
// Module   : mul_sequencer
// Brief    : Radix-2 shift-add multiply controller that stalls EX for DATA_W+1 cycles
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_sequencer #(
    parameter int         DATA_W   = 32,
    parameter logic [3:0] MUL_CODE = 4'd8
) (
    input  logic          clk,
    input  logic          arst_n,
    mul_sequencer_if.slave bus
);
    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              result_valid_q, result_valid_d;

    logic              w_go;
    logic [DATA_W-1:0] w_acc_sum;

    assign w_go      = bus.ex_valid && (bus.alu_control == MUL_CODE) && !bus.flush;
    assign w_acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        result_d       = result_q;
        cnt_d          = cnt_q;
        busy_d         = 1'b0;
        result_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_go) begin
                    acc_d    = '0;
                    mcand_d  = bus.operand_a;
                    mplier_d = bus.operand_b;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d    = w_acc_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == C_LAST) begin
                        result_d       = w_acc_sum;
                        result_valid_d = 1'b1;
                        state_d        = DONE;
                    end else begin
                        busy_d = 1'b1;
                    end
                end
            end
            // DONE never restarts: the same mul is still sitting in EX this cycle
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            mcand_q        <= '0;
            mplier_q       <= '0;
            result_q       <= '0;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            mcand_q        <= mcand_d;
            mplier_q       <= mplier_d;
            result_q       <= result_d;
            cnt_q          <= cnt_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Gated by arst_n so stall drops at once on reset even with a mul held in EX
    assign bus.stall        = arst_n && !bus.flush && (((state_q == IDLE) && w_go) || (state_q == RUN));
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_sequencer.sv
// ============================================================================
// Module   : tb_mul_sequencer
// Brief    : Directed self-checking bench for mul_sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mul_sequencer;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mul_sequencer_if #(.DATA_W(DW)) bus ();

    mul_sequencer #(.DATA_W(DW), .MUL_CODE(4'd8)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus.slave)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] code, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic fl);
        bus.ex_valid    = v;
        bus.alu_control = code;
        bus.operand_a   = a;
        bus.operand_b   = b;
        bus.flush       = fl;
    endtask

    // Full mul occupancy: cycles 0..DW+1; operands scrambled after cycle 0
    task automatic do_mul(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] exp);
        for (int cyc = 0; cyc <= DW + 1; cyc++) begin
            if (cyc == 0) drive(1'b1, 4'd8, a, b, 1'b0);
            else drive(1'b1, 4'd8, ~a, ~b, 1'b0);
            @(negedge clk);
            chk({tag, "_stall"}, DW'(bus.stall), DW'(cyc <= DW));
            chk({tag, "_busy"},  DW'(bus.busy),  DW'(cyc >= 1 && cyc <= DW));
            chk({tag, "_rv"},    DW'(bus.result_valid), DW'(cyc == DW + 1));
            if (cyc == DW + 1) chk({tag, "_result"}, bus.result, exp);
            next_cycle();
        end
    endtask

    initial begin
        drive(1'b0, 4'd0, '0, '0, 1'b0);
        #12;
        chk("rst_stall",  DW'(bus.stall), '0);
        chk("rst_busy",   DW'(bus.busy), '0);
        chk("rst_rv",     DW'(bus.result_valid), '0);
        chk("rst_result", bus.result, '0);
        @(negedge clk);
        arst_n = 1'b1;
        next_cycle();

        do_mul("m3x5", 32'd3, 32'd5, 32'h0000_000F);
        drive(1'b0, 4'd0, '0, '0, 1'b0);
        @(negedge clk);
        chk("hold_result", bus.result, 32'h0000_000F);
        chk("hold_rv", DW'(bus.result_valid), '0);
        next_cycle();

        do_mul("neg2x3", 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA);
        do_mul("m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        do_mul("wrap", 32'h8000_0000, 32'd2, 32'h0000_0000);

        // Non-multiply codes keep the block idle
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, (k < 2) ? 4'd2 : 4'd5, 32'd9, 32'd9, 1'b0);
            @(negedge clk);
            chk("nonmul_stall", DW'(bus.stall), '0);
            chk("nonmul_busy",  DW'(bus.busy), '0);
            chk("nonmul_rv",    DW'(bus.result_valid), '0);
            next_cycle();
        end

        // Mul with ex_valid low
        drive(1'b0, 4'd8, 32'd9, 32'd9, 1'b0);
        @(negedge clk);
        chk("novalid_stall", DW'(bus.stall), '0);
        next_cycle();
        chk("novalid_busy", DW'(bus.busy), '0);

        // Flush coinciding with go
        drive(1'b1, 4'd8, 32'd9, 32'd9, 1'b1);
        @(negedge clk);
        chk("flushgo_stall", DW'(bus.stall), '0);
        next_cycle();
        drive(1'b0, 4'd0, '0, '0, 1'b0);
        @(negedge clk);
        chk("flushgo_busy", DW'(bus.busy), '0);
        chk("flushgo_stall2", DW'(bus.stall), '0);
        next_cycle();

        // Back-to-back with a single unstalled DONE cycle between
        do_mul("b2b_a", 32'd7, 32'd6, 32'd42);
        do_mul("b2b_b", 32'h0001_0000, 32'h0001_0000, 32'd0);
        drive(1'b0, 4'd0, '0, '0, 1'b0);
        next_cycle();

        // Flush abort in cycle 10 of 9x9
        for (int cyc = 0; cyc <= 10; cyc++) begin
            drive(1'b1, 4'd8, 32'd9, 32'd9, cyc == 10);
            @(negedge clk);
            chk("abort_stall", DW'(bus.stall), DW'(cyc < 10));
            next_cycle();
        end
        drive(1'b0, 4'd0, '0, '0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_busy",   DW'(bus.busy), '0);
            chk("abort_rv",     DW'(bus.result_valid), '0);
            chk("abort_result", bus.result, '0);
            next_cycle();
        end
        do_mul("m2x2", 32'd2, 32'd2, 32'd4);

        // Reset asserted in cycle 20 of a run, mul left in EX
        for (int cyc = 0; cyc < 20; cyc++) begin
            drive(1'b1, 4'd8, 32'h0000_1234, 32'h0000_0100, 1'b0);
            next_cycle();
        end
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_stall",  DW'(bus.stall), '0);
        chk("arst_busy",   DW'(bus.busy), '0);
        chk("arst_rv",     DW'(bus.result_valid), '0);
        chk("arst_result", bus.result, '0);
        next_cycle();
        #2;
        arst_n = 1'b1;
        do_mul("after_rst", 32'h0000_1234, 32'h0000_0100, 32'h0012_3400);
        drive(1'b0, 4'd0, '0, '0, 1'b0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle multiply controller for the EX stage. It detects an R-type `mul` (ALU control code 4'd8) entering EX and runs a radix-2 shift-add multiply over DATA_W cycles. While the multiply runs, it holds the pipeline with `stall`, then presents the low DATA_W bits of the product for one cycle. It sits beside the ALU, and the EX result mux selects `result` when `result_valid` is high.

## Interface
- DATA_W, 32, operand/result width (≥2)
- MUL_CODE, 4'd8, ALU control code that triggers a multiply
- clk  in  1  rising-edge clock
- arst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX stage holds a valid instruction
- alu_control  in  4  ALU control code of the EX instruction
- operand_a  in  DATA_W  multiplicand (rs)
- operand_b  in  DATA_W  multiplier (rt)
- flush  in  1  synchronous pipeline flush of EX
- stall  out  1  freeze IF/ID/EX; combinational
- busy  out  1  registered; high in RUN
- result  out  DATA_W  low DATA_W bits of a*b; valid only with result_valid
- result_valid  out  1  registered; one-cycle pulse

## Operation
- Clock and reset: one clock, `clk`. Reset `arst_n` is asynchronous and active-low.
- Reset values:
  - State is IDLE.
  - `busy`=0, `result_valid`=0, `result`=0, `stall`=0.
  - Accumulator, shifted multiplicand, multiplier and counter are 0.
- Trigger: `go` = `ex_valid` & (`alu_control`==MUL_CODE) & ~`flush`.
- IDLE:
  - On `go`, latch `acc`=0, `mcand`=`operand_a`, `mplier`=`operand_b`, `cnt`=0, and go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - If `mplier[0]`, then `acc` += `mcand` (mod 2^DATA_W).
  - `mcand` <<= 1, `mplier` >>= 1, `cnt`++.
  - When `cnt`==DATA_W-1, write the final `acc` into `result` and go to DONE.
- DONE:
  - `result_valid`=1 for this cycle only.
  - Go to IDLE unconditionally. Never restart from DONE, even though the same `mul` is still in EX.
- `stall` = (IDLE & `go`) | RUN, with both terms gated by ~`flush`. `stall` is 0 in DONE, so the pipeline advances and captures `result`.
- Signedness: only the low DATA_W bits are produced, so one unsigned shift-add serves both signed and unsigned operands. No sign correction is needed.
- `flush` in RUN: go to IDLE next edge, no `result_valid`, `stall` low in that same cycle.
- `flush` in DONE: `result_valid` is still pulsed. The pipeline ignores it.
- Non-MUL codes (add, sub, and, or, nor, slt, sll, srl) and `ex_valid`=0 never leave IDLE and never raise `stall`.
- Operands are sampled only at the IDLE→RUN edge. Operand changes during RUN are ignored.
- `result` holds its last value until the next DONE.

## Timing
- Cycle numbering: cycle 0 is the first cycle `go` is high in IDLE.
  - `stall` is high in cycles 0..DATA_W (DATA_W+1 cycles).
  - `busy` is high in cycles 1..DATA_W.
  - DONE and `result_valid` fall in cycle DATA_W+1.
- Total `mul` occupancy of EX is DATA_W+2 cycles (default 34).
- Back-to-back: a second `mul` arriving in EX in the cycle after DONE re-enters RUN with no bubble.
- `arst_n` low at any point, including mid-RUN: the state and every output reach their reset values immediately, without waiting for a clock edge. After release, the block starts in IDLE, and any `mul` still in EX is re-triggered once `go` is high.
- A `flush` coinciding with `go` in IDLE: no start, `stall`=0.

## Test plan
- Basic multiply: `mul` with a=3, b=5 → `stall` high for 33 cycles, `result_valid` pulses at cycle 33 with `result`=0x0000000F, and `stall`=0 in that cycle.
- Signed and wrap-around cases:
  - a=0xFFFFFFFE (-2), b=3 → `result`=0xFFFFFFFA.
  - a=b=0xFFFFFFFF → `result`=0x00000001.
  - a=0x80000000, b=2 → `result`=0.
- Non-multiply ops: `alu_control`=4'd2 and 4'd5 with `ex_valid`=1 → `stall`, `busy` and `result_valid` stay 0 and the state stays IDLE.
- Back-to-back: `mul` 7×6 then, one cycle after DONE, `mul` 0x10000×0x10000 → `result`=42, then `result`=0. There are two separate 33-cycle stall windows with exactly one unstalled cycle between them.
- Flush abort: `flush` in cycle 10 of a 9×9 multiply → `stall` drops in cycle 10, IDLE next, and no `result_valid`. A following 2×2 returns 4.
- Reset mid-run: `arst_n` low in cycle 20 → `stall`, `busy`, `result_valid` and `result` go to 0 before the next clock edge. After release with the `mul` still in EX, the multiply runs a fresh 33-cycle window and returns the correct product.
